shift_arb_ctrl: RTL and testbench
=================================

Name: shift_arb_ctrl

Overview:
Two-requester round-robin scheduler for one shared parallel-load, serial-out shift register. Each requester presents a W-bit word. The controller grants the register to one requester, loads the word, shifts it out MSB-first on a single serial line, and then signals completion. It sits between word-level producers and a single serial output path.

Parameters:
W, 8, data word width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
req  input  2  level request, one bit per requester; req[i] asks for one word transfer from d_i.
d0  input  W  word from requester 0; sampled only on the grant edge.
d1  input  W  word from requester 1; sampled only on the grant edge.
gnt  output  2  registered one-hot grant; 00 when no requester is granted.
busy  output  1  high whenever the state is not idle.
sout  output  1  serial data; the MSB of the shift register while shifting, otherwise 0.
done_tick  output  2  one-cycle pulse on the bit of the requester whose transfer has just finished.

Behaviour:
- Reset values: state=idle, gnt=00, busy=0, sout=0, done_tick=00, cnt=0, sreg=0, last=1 (so requester 0 wins the first tie).
- FSM states: idle, shift, done.
- idle:
  - If req=00, stay in idle.
  - Otherwise pick sel on the grant edge (E0):
    - exactly one req bit set: sel is that requester;
    - both set: sel = ~last.
  - At E0: sreg<=d_sel, cnt<=0, gnt<=onehot(sel), last<=sel, state<=shift.
- shift:
  - sout=sreg[W-1].
  - On each edge: if cnt==W-1, state<=done; else sreg<=sreg<<1 and cnt<=cnt+1.
  - Bit k (MSB = bit 0) is driven during cycle k+1 after E0, for k=0..W-1.
- done:
  - done_tick=gnt for exactly one cycle (cycle W+1 after E0); sout=0.
  - Next edge: gnt<=00, state<=idle.
- Arbitration happens only in idle, so back-to-back transfers have a period of W+2 cycles.
- Requests are levels:
  - A requester must drop req in the cycle done_tick is seen, or it is served again.
  - A re-serve is still subject to round-robin against the other requester.
- Deasserting req during shift or done is ignored; the transfer completes.
- Changing d0/d1 after E0 has no effect on the transfer in progress.
- Reset asserted in any state overrides all else at that edge and restores every reset value. The aborted transfer produces no done_tick.
- cnt width is clog2(W); no wrap-around occurs because cnt is cleared on every grant.
- busy and done_tick are Moore outputs decoded from state and gnt; gnt is a register.

Decomposition:
- Package shift_arb_pkg holds:
  - the state encoding constants (idle, shift, done, 2-bit);
  - the requester count constant N_REQ=2;
  - a width helper for cnt.
- One sub-module, rr_arb2: combinational 2-way round-robin select.
  - Inputs: req[1:0] and last.
  - Outputs: sel and a valid flag.
  - The last register stays in shift_arb_ctrl.

Test Plan:
1. Reset held for 2 cycles, then released with req=00 -> gnt=00, busy=0, sout=0, done_tick=00 for 10 cycles.
2. W=8, req=01, d0=0xA5 -> gnt=01 after E0; sout=1,0,1,0,0,1,0,1 on cycles 1-8; done_tick=01 on cycle 9; gnt=00 and busy=0 on cycle 10.
3. W=8, req=11 held, d0=0x0F, d1=0xF0 -> requester 0 is served first (sout 0000_1111), then requester 1 (1111_0000). Grant edges are 10 cycles apart, and the third grant goes back to requester 0.
4. req=10 with d1=0xFF; req drops to 00 on cycle 3 and d1 changes to 0x00 -> all 8 bits of sout are 1, and done_tick=10 on cycle 9.
5. req=01 with d0=0xFF; reset pulses on cycle 4 -> the next cycle shows idle with all outputs 0 and no done_tick. After release, with req=11, requester 0 is granted first (last is reset to 1).
6. Build with W=4, req=01, d0=0x9 -> sout=1,0,0,1 on cycles 1-4; done_tick=01 on cycle 5; period is 6 cycles with req held.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared constants for the two-requester serial shift scheduler.
package shift_arb_pkg;

  localparam int unsigned N_REQ = 2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Bit counter width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w <= 2) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin select; the history bit lives in the caller.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    unique case (req_i)
      2'b01:   sel_o = 1'b0;
      2'b10:   sel_o = 1'b1;
      2'b11:   sel_o = ~last_i;
      default: sel_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_arb_ctrl.sv
// Grants one shared parallel-load shift register to two requesters in round-robin
// order and shifts the granted word out MSB-first.
module shift_arb_ctrl
  import shift_arb_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             sout,
  output logic [N_REQ-1:0] done_tick
);

  localparam int unsigned CW = cnt_width(W);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     sreg_q, sreg_d;
  logic             last_q, last_d;
  logic             sel, sel_vld;

  rr_arb2 u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .sel_o   (sel),
    .valid_o (sel_vld)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (sel_vld) begin
          sreg_d  = sel ? d1 : d0;
          cnt_d   = '0;
          gnt_d   = sel ? 2'b10 : 2'b01;
          last_d  = sel;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == CW'(W - 1)) begin
          state_d = StDone;
        end else begin
          sreg_d = {sreg_q[W-2:0], 1'b0};
          cnt_d  = cnt_q + CW'(1);
        end
      end
      StDone: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    gnt       = gnt_q;
    busy      = (state_q != StIdle);
    sout      = (state_q == StShift) ? sreg_q[W-1] : 1'b0;
    done_tick = (state_q == StDone) ? gnt_q : '0;
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl: vector table plus hand-written corner sequences.
module tb_shift_arb_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, req4;
  logic [7:0] d0, d1;
  logic [3:0] d04, d14;
  logic [1:0] gnt, done_tick, gnt4, done_tick4;
  logic       busy, sout, busy4, sout4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_arb_ctrl #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .gnt       (gnt),
    .busy      (busy),
    .sout      (sout),
    .done_tick (done_tick)
  );

  shift_arb_ctrl #(.W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .req       (req4),
    .d0        (d04),
    .d1        (d14),
    .gnt       (gnt4),
    .busy      (busy4),
    .sout      (sout4),
    .done_tick (done_tick4)
  );

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_gnt;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    req4  = 2'b00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full transfer from idle; inputs scrambled after the grant edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req = v.req;
    d0  = v.d0;
    d1  = v.d1;
    @(posedge clk);
    #1;
    chk("vec_gnt", gnt, v.exp_gnt);
    chk("vec_busy", busy, 1);
    req = 2'b00;
    d0  = ~v.d0;
    d1  = ~v.d1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("vec_sout", sout, v.exp_word[7-k]);
    end
    @(posedge clk);
    #1;
    chk("vec_done_tick", done_tick, v.exp_gnt);
    chk("vec_done_sout", sout, 0);
    @(posedge clk);
    #1;
    chk("vec_idle", {gnt, busy, done_tick}, 0);
  endtask

  logic [1:0] gs[30];
  logic [1:0] ds[30];
  logic       ss[30];
  logic [7:0] w;

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    req4  = 2'b00;
    d0    = 8'h00;
    d1    = 8'h00;
    d04   = 4'h0;
    d14   = 4'h0;

    // Last starts at 1 after reset; expected grants follow round-robin history.
    vecs[0] = '{req: 2'b01, d0: 8'hA5, d1: 8'h00, exp_gnt: 2'b01, exp_word: 8'hA5};
    vecs[1] = '{req: 2'b10, d0: 8'h00, d1: 8'h3C, exp_gnt: 2'b10, exp_word: 8'h3C};
    vecs[2] = '{req: 2'b11, d0: 8'h0F, d1: 8'hF0, exp_gnt: 2'b01, exp_word: 8'h0F};
    vecs[3] = '{req: 2'b11, d0: 8'h0F, d1: 8'hF0, exp_gnt: 2'b10, exp_word: 8'hF0};
    vecs[4] = '{req: 2'b11, d0: 8'h81, d1: 8'h7E, exp_gnt: 2'b01, exp_word: 8'h81};
    vecs[5] = '{req: 2'b01, d0: 8'h00, d1: 8'hFF, exp_gnt: 2'b01, exp_word: 8'h00};
    vecs[6] = '{req: 2'b11, d0: 8'h11, d1: 8'hEE, exp_gnt: 2'b10, exp_word: 8'hEE};

    // Reset then quiet idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_outputs", {gnt, busy, sout, done_tick}, 0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Held 11 request: alternating grants, period 10.
    do_reset();
    @(negedge clk);
    req = 2'b11;
    d0  = 8'h0F;
    d1  = 8'hF0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      gs[i] = gnt;
      ds[i] = done_tick;
      ss[i] = sout;
    end
    req = 2'b00;
    chk("b2b_gnt0", gs[0], 2'b01);
    chk("b2b_gap0", gs[9], 2'b00);
    chk("b2b_gnt1", gs[10], 2'b10);
    chk("b2b_gap1", gs[19], 2'b00);
    chk("b2b_gnt2", gs[20], 2'b01);
    chk("b2b_done0", ds[8], 2'b01);
    chk("b2b_done1", ds[18], 2'b10);
    chk("b2b_nodone", ds[9], 2'b00);
    w = 8'h0F;
    for (int k = 0; k < 8; k++) chk("b2b_sout0", ss[k], w[7-k]);
    w = 8'hF0;
    for (int k = 0; k < 8; k++) chk("b2b_sout1", ss[10+k], w[7-k]);
    chk("b2b_done_sout", ss[8], 0);
    repeat (12) @(posedge clk);

    // Request and data dropped mid-transfer are ignored.
    do_reset();
    @(negedge clk);
    req = 2'b10;
    d1  = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        req = 2'b00;
        d1  = 8'h00;
      end
      if (c <= 8) chk("drop_sout", sout, 1);
      if (c == 1) chk("drop_gnt", gnt, 2'b10);
      if (c == 9) chk("drop_done", done_tick, 2'b10);
      if (c == 10) chk("drop_idle", {gnt, busy, done_tick}, 0);
    end

    // Reset mid-transfer aborts without a done tick.
    do_reset();
    @(negedge clk);
    req = 2'b01;
    d0  = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      chk("abort_sout", sout, 1);
    end
    reset = 1'b1;
    req   = 2'b00;
    @(posedge clk);
    #1;
    chk("abort_reset_out", {gnt, busy, sout, done_tick}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk("abort_quiet", {gnt, busy, done_tick}, 0);
    end
    @(negedge clk);
    req = 2'b11;
    d0  = 8'h55;
    d1  = 8'hAA;
    @(posedge clk);
    #1;
    chk("abort_tie_gnt", gnt, 2'b01);
    chk("abort_tie_sout", sout, 0);
    req = 2'b00;
    repeat (12) @(posedge clk);

    // W=4 instance, request held: period 6.
    @(negedge clk);
    req4 = 2'b01;
    d04  = 4'h9;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      gs[i] = gnt4;
      ds[i] = done_tick4;
      ss[i] = sout4;
    end
    req4 = 2'b00;
    chk("w4_sout0", ss[0], 1);
    chk("w4_sout1", ss[1], 0);
    chk("w4_sout2", ss[2], 0);
    chk("w4_sout3", ss[3], 1);
    chk("w4_gnt0", gs[0], 2'b01);
    chk("w4_done0", ds[4], 2'b01);
    chk("w4_gap", gs[5], 2'b00);
    chk("w4_gnt1", gs[6], 2'b01);
    chk("w4_done1", ds[10], 2'b01);
    chk("w4_gnt2", gs[12], 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
